// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, widths and panel-sequencer state encoding for the
// RGB-interface LCD driver.
package lcd_timing_pkg;

  localparam int unsigned RGB_W = 16;
  localparam int unsigned CNT_W = 11;

  // 4.3" 480x272 panel (default)
  localparam int unsigned LCD43_H_SYNC  = 41;
  localparam int unsigned LCD43_H_BACK  = 2;
  localparam int unsigned LCD43_H_DISP  = 480;
  localparam int unsigned LCD43_H_FRONT = 2;
  localparam int unsigned LCD43_V_SYNC  = 10;
  localparam int unsigned LCD43_V_BACK  = 2;
  localparam int unsigned LCD43_V_DISP  = 272;
  localparam int unsigned LCD43_V_FRONT = 2;

  // 7" 800x480 panel
  localparam int unsigned LCD70_H_SYNC  = 128;
  localparam int unsigned LCD70_H_BACK  = 88;
  localparam int unsigned LCD70_H_DISP  = 800;
  localparam int unsigned LCD70_H_FRONT = 40;
  localparam int unsigned LCD70_V_SYNC  = 2;
  localparam int unsigned LCD70_V_BACK  = 33;
  localparam int unsigned LCD70_V_DISP  = 480;
  localparam int unsigned LCD70_V_FRONT = 10;

  localparam int unsigned LCD_RST_CYC   = 1000;

  typedef enum logic [1:0] {
    SEQ_RST_HOLD   = 2'd0,
    SEQ_WAIT_FRAME = 2'd1,
    SEQ_RUN        = 2'd2
  } seq_state_e;

endpackage

// File: rtl/lcd_panel_seq.sv
// Power-up sequencer: holds the panel in reset, waits for a frame boundary,
// then enables the backlight.
module lcd_panel_seq
  import lcd_timing_pkg::*;
#(
  parameter int unsigned RST_CYC = LCD_RST_CYC
) (
  input  logic lcd_pclk,
  input  logic rst_n,
  input  logic frame_start,
  output logic lcd_rst,
  output logic lcd_bl
);

  localparam int unsigned RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);

  seq_state_e       state, state_next;
  logic [RST_W-1:0] rst_cnt, cnt_next;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEQ_RST_HOLD;
      rst_cnt <= '0;
    end else begin
      state   <= state_next;
      rst_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = rst_cnt;
    case (state)
      SEQ_RST_HOLD: begin
        if (rst_cnt == RST_LAST) state_next = SEQ_WAIT_FRAME;
        else                     cnt_next   = rst_cnt + RST_W'(1);
      end
      SEQ_WAIT_FRAME: begin
        if (frame_start) state_next = SEQ_RUN;
      end
      SEQ_RUN: state_next = SEQ_RUN;
      default: state_next = SEQ_RST_HOLD;
    endcase
  end

  // Outputs registered from the next state so they track the state register.
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_rst <= 1'b0;
      lcd_bl  <= 1'b0;
    end else begin
      lcd_rst <= (state_next != SEQ_RST_HOLD);
      lcd_bl  <= (state_next == SEQ_RUN);
    end
  end

endmodule

// File: rtl/lcd_rgb_driver.sv
// RGB LCD timing generator: free-running H/V counters, sync/DE decode, early
// pixel request with coordinates, and the panel power-up sequencer.
module lcd_rgb_driver
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC  = LCD43_H_SYNC,
  parameter int unsigned H_BACK  = LCD43_H_BACK,
  parameter int unsigned H_DISP  = LCD43_H_DISP,
  parameter int unsigned H_FRONT = LCD43_H_FRONT,
  parameter int unsigned V_SYNC  = LCD43_V_SYNC,
  parameter int unsigned V_BACK  = LCD43_V_BACK,
  parameter int unsigned V_DISP  = LCD43_V_DISP,
  parameter int unsigned V_FRONT = LCD43_V_FRONT,
  parameter int unsigned PIX_LAT = 1,
  parameter int unsigned RST_CYC = LCD_RST_CYC
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic [RGB_W-1:0]  pixel_data,
  output logic              data_req,
  output logic [CNT_W-1:0]  pixel_xpos,
  output logic [CNT_W-1:0]  pixel_ypos,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [RGB_W-1:0]  lcd_rgb,
  output logic              frame_start,
  output logic              lcd_rst,
  output logic              lcd_bl
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] H_REQ_BEG = CNT_W'(H_SYNC + H_BACK - PIX_LAT);
  localparam logic [CNT_W-1:0] H_REQ_END = CNT_W'(H_SYNC + H_BACK + H_DISP - PIX_LAT);
  localparam logic [CNT_W-1:0] V_ACT_BEG = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_SYNC + V_BACK + V_DISP);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_act, h_de, h_req;

  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + CNT_W'(1);
      if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end
  end

  // Video outputs are pure decodes of the counters; only lcd_rgb sees an input.
  assign v_act = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign h_de  = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
  assign h_req = (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);

  assign lcd_hs      = (h_cnt >= H_SYNC_E);
  assign lcd_vs      = (v_cnt >= V_SYNC_E);
  assign lcd_de      = v_act && h_de;
  assign data_req    = v_act && h_req;
  assign pixel_xpos  = data_req ? (h_cnt - H_REQ_BEG + CNT_W'(1)) : '0;
  assign pixel_ypos  = data_req ? (v_cnt - V_ACT_BEG + CNT_W'(1)) : '0;
  assign lcd_rgb     = lcd_de ? pixel_data : '0;
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

  lcd_panel_seq #(
    .RST_CYC (RST_CYC)
  ) u_panel_seq (
    .lcd_pclk    (lcd_pclk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .lcd_rst     (lcd_rst),
    .lcd_bl      (lcd_bl)
  );

endmodule

// File: tb/tb_lcd_rgb_driver.sv
// Bench for lcd_rgb_driver: default panel plus three shrunken timings with
// PIX_LAT 0/1/3, a reference timing model and a pixel scoreboard per instance.
module tb_lcd_rgb_driver;

  localparam int NI = 4;
  localparam int P_HS  [NI] = '{41, 4, 4, 4};
  localparam int P_HB  [NI] = '{2, 2, 2, 2};
  localparam int P_HD  [NI] = '{480, 16, 16, 16};
  localparam int P_HF  [NI] = '{2, 2, 2, 2};
  localparam int P_VS  [NI] = '{10, 2, 2, 2};
  localparam int P_VB  [NI] = '{2, 2, 2, 2};
  localparam int P_VD  [NI] = '{272, 6, 6, 6};
  localparam int P_VF  [NI] = '{2, 2, 2, 2};
  localparam int P_LAT [NI] = '{1, 0, 1, 3};
  localparam int P_RST [NI] = '{1000, 20, 20, 20};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pix [NI];
  logic [15:0] rgb [NI];
  logic [10:0] xp  [NI];
  logic [10:0] yp  [NI];
  logic        req [NI];
  logic        hs  [NI];
  logic        vs  [NI];
  logic        de  [NI];
  logic        fs  [NI];
  logic        lrst[NI];
  logic        bl  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    lcd_rgb_driver #(
      .H_SYNC (P_HS[g]), .H_BACK (P_HB[g]), .H_DISP (P_HD[g]), .H_FRONT (P_HF[g]),
      .V_SYNC (P_VS[g]), .V_BACK (P_VB[g]), .V_DISP (P_VD[g]), .V_FRONT (P_VF[g]),
      .PIX_LAT (P_LAT[g]), .RST_CYC (P_RST[g])
    ) u_dut (
      .lcd_pclk    (clk),
      .rst_n       (rst_n),
      .pixel_data  (pix[g]),
      .data_req    (req[g]),
      .pixel_xpos  (xp[g]),
      .pixel_ypos  (yp[g]),
      .lcd_hs      (hs[g]),
      .lcd_vs      (vs[g]),
      .lcd_de      (de[g]),
      .lcd_rgb     (rgb[g]),
      .frame_start (fs[g]),
      .lcd_rst     (lrst[g]),
      .lcd_bl      (bl[g])
    );

    // Pixel source: returns {ypos[4:0], xpos} PIX_LAT cycles after the request
    logic [15:0] pipe [4];
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= {yp[g][4:0], xp[g]};
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
    end
    if (P_LAT[g] == 0) begin : g_l0
      assign pix[g] = {yp[g][4:0], xp[g]};
    end else begin : g_ln
      assign pix[g] = pipe[P_LAT[g]-1];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [15:0] q0[$], q1[$], q2[$], q3[$];

  task automatic sb_push(input int i, input logic [15:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int i, output logic [15:0] v);
    v = '0;
    case (i)
      0: if (q0.size() > 0) v = q0.pop_front();
      1: if (q1.size() > 0) v = q1.pop_front();
      2: if (q2.size() > 0) v = q2.pop_front();
      default: if (q3.size() > 0) v = q3.pop_front();
    endcase
  endtask

  // Reference timing: {hs, vs, de, req, xpos, ypos, frame_start}
  function automatic logic [26:0] model_vid(input int i, input int c);
    int ht, vt, h, v, ab, rb, vb;
    logic va, d, r;
    logic [10:0] x, y;
    ht = P_HS[i] + P_HB[i] + P_HD[i] + P_HF[i];
    vt = P_VS[i] + P_VB[i] + P_VD[i] + P_VF[i];
    h  = c % ht;
    v  = (c / ht) % vt;
    ab = P_HS[i] + P_HB[i];
    rb = ab - P_LAT[i];
    vb = P_VS[i] + P_VB[i];
    va = (v >= vb) && (v < vb + P_VD[i]);
    d  = va && (h >= ab) && (h < ab + P_HD[i]);
    r  = va && (h >= rb) && (h < rb + P_HD[i]);
    x  = r ? 11'(h - rb + 1) : 11'd0;
    y  = r ? 11'(v - vb + 1) : 11'd0;
    return {h >= P_HS[i], v >= P_VS[i], d, r, x, y, (h == 0) && (v == 0)};
  endfunction

  int first_req[NI], first_de[NI], first_bl[NI], rst_low[NI];
  int de_f0[NI], hs_l0[NI], vs_f0[NI];
  logic [15:0] first_rgb[NI];
  logic [15:0] last_small;

  task automatic clear_stats();
    for (int i = 0; i < NI; i++) begin
      first_req[i] = -1; first_de[i] = -1; first_bl[i] = -1;
      rst_low[i] = 0; de_f0[i] = 0; hs_l0[i] = 0; vs_f0[i] = 0;
      first_rgb[i] = '0;
    end
    last_small = '0;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  task automatic sample_all();
    logic [26:0] e;
    logic [15:0] er;
    int ht, fr, fsc;
    for (int i = 0; i < NI; i++) begin
      ht  = P_HS[i] + P_HB[i] + P_HD[i] + P_HF[i];
      fr  = ht * (P_VS[i] + P_VB[i] + P_VD[i] + P_VF[i]);
      fsc = ((P_RST[i] + fr - 1) / fr) * fr;
      e = model_vid(i, cyc);
      check($sformatf("video%0d", i), {hs[i], vs[i], de[i], req[i], xp[i], yp[i], fs[i]}, e);
      if (e[23]) sb_push(i, {e[5:1], e[22:12]});
      er = '0;
      if (e[24]) sb_pop(i, er);
      check($sformatf("rgb%0d", i), rgb[i], er);
      check($sformatf("panel%0d", i), {lrst[i], bl[i]}, {cyc >= P_RST[i], cyc > fsc});
      if (req[i] && first_req[i] < 0) first_req[i] = cyc;
      if (de[i] && first_de[i] < 0) begin first_de[i] = cyc; first_rgb[i] = rgb[i]; end
      if (bl[i] && first_bl[i] < 0) first_bl[i] = cyc;
      if (!lrst[i]) rst_low[i]++;
      if (cyc < fr && de[i]) de_f0[i]++;
      if (cyc < ht && !hs[i]) hs_l0[i]++;
      if (cyc < fr && !vs[i]) vs_f0[i]++;
      if (i == 2 && cyc == 237) last_small = rgb[i];
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      sample_all();
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s%0d", tag, i),
            {hs[i], vs[i], de[i], req[i], xp[i], yp[i], fs[i], rgb[i], lrst[i], bl[i]},
            {4'b0000, 22'd0, 1'b1, 16'h0000, 2'b00});
  endtask

  initial begin
    rst_n = 1'b0;
    cyc = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Run the default panel up to v_cnt=100, h_cnt=200
    run(52701);
    check("hs_low_line", 64'(hs_l0[0]), 64'd41);
    check("vs_low_frame", 64'(vs_f0[0]), 64'd5250);
    check("rst_low_def", 64'(rst_low[0]), 64'd1000);
    check("first_req_def", 64'(first_req[0]), 64'd6342);
    check("first_de_def", 64'(first_de[0]), 64'd6343);
    check("first_rgb_def", 64'(first_rgb[0]), 64'h0801);
    for (int i = 1; i < NI; i++) begin
      check($sformatf("de_per_frame%0d", i), 64'(de_f0[i]), 64'd96);
      check($sformatf("req_lead%0d", i), 64'(first_de[i] - first_req[i]), 64'(P_LAT[i]));
      check($sformatf("first_req%0d", i), 64'(first_req[i]), 64'(102 - P_LAT[i]));
      check($sformatf("first_rgb%0d", i), 64'(first_rgb[i]), 64'h0801);
      check($sformatf("bl_rise%0d", i), 64'(first_bl[i]), 64'd289);
      check($sformatf("rst_low%0d", i), 64'(rst_low[i]), 64'd20);
    end
    check("last_rgb_small", 64'(last_small), 64'h3010);

    // Asynchronous reset away from any clock edge
    cyc = 52700;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    clear_stats();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    run(1100);
    check("rst_low_again_def", 64'(rst_low[0]), 64'd1000);
    for (int i = 1; i < NI; i++)
      check($sformatf("rst_low_again%0d", i), 64'(rst_low[i]), 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_rgb_driver.md
# lcd_rgb_driver

RGB-interface LCD timing generator that sits between the pixel source (`lcd_display`) and the panel pins. It runs horizontal and vertical counters on `lcd_pclk` and drives active-low HSYNC/VSYNC, DE and RGB565 data. It also issues the pixel request and X/Y coordinates early, so a registered pixel source has its data ready exactly when DE rises. It also sequences panel reset and backlight after power-up.

## Interface
Parameters:
- `H_SYNC`, 41: HSYNC width, pclk cycles
- `H_BACK`, 2: horizontal back porch
- `H_DISP`, 480: active pixels per line
- `H_FRONT`, 2: horizontal front porch
- `V_SYNC`, 10: VSYNC width, lines
- `V_BACK`, 2: vertical back porch
- `V_DISP`, 272: active lines
- `V_FRONT`, 2: vertical front porch
- `PIX_LAT`, 1: pixel-source latency, cycles from request to valid `pixel_data`; legal range 0..H_SYNC+H_BACK
- `RST_CYC`, 1000: cycles `lcd_rst` is held low after `rst_n` release

Ports:
- `lcd_pclk`, in, 1: pixel clock
- `rst_n`, in, 1: reset, asynchronous, active-low
- `pixel_data`, in, 16: RGB565 from pixel source, valid PIX_LAT cycles after request
- `data_req`, out, 1: pixel request, leads `lcd_de` by PIX_LAT
- `pixel_xpos`, out, 11: requested X, 1-based, 0 when idle
- `pixel_ypos`, out, 11: requested Y, 1-based, 0 when idle
- `lcd_hs`, out, 1: HSYNC, active-low
- `lcd_vs`, out, 1: VSYNC, active-low
- `lcd_de`, out, 1: data enable
- `lcd_rgb`, out, 16: panel data
- `frame_start`, out, 1: one-cycle pulse at h_cnt=0, v_cnt=0
- `lcd_rst`, out, 1: panel reset, active-low
- `lcd_bl`, out, 1: backlight enable

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (525). V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (286). Both counters are 11 bits.
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments only when h_cnt=H_TOTAL-1, and wraps to 0 when v_cnt=V_TOTAL-1 coincides with the h wrap.
- `lcd_hs` = 0 when h_cnt < H_SYNC. `lcd_vs` = 0 when v_cnt < V_SYNC.
- v_act = V_SYNC+V_BACK ≤ v_cnt < V_SYNC+V_BACK+V_DISP.
- `lcd_de` = v_act && H_SYNC+H_BACK ≤ h_cnt < H_SYNC+H_BACK+H_DISP.
- `data_req` = v_act && H_SYNC+H_BACK-PIX_LAT ≤ h_cnt < H_SYNC+H_BACK+H_DISP-PIX_LAT.
- `pixel_xpos` = data_req ? h_cnt-(H_SYNC+H_BACK-PIX_LAT)+1 : 0, giving range 1..H_DISP.
- `pixel_ypos` = data_req ? v_cnt-(V_SYNC+V_BACK)+1 : 0, giving range 1..V_DISP.
- `lcd_rgb` = lcd_de ? pixel_data : 16'h0000.
- Counters and the video outputs free-run from `rst_n` release, independent of the panel sequence.
- Panel sequencer FSM:
  - RST_HOLD: `lcd_rst`=0, `lcd_bl`=0; count RST_CYC cycles, then go to WAIT_FRAME.
  - WAIT_FRAME: `lcd_rst`=1, `lcd_bl`=0; on `frame_start`, go to RUN.
  - RUN: `lcd_rst`=1, `lcd_bl`=1; terminal state.
- Reset mid-frame or mid-sequence: counters return to 0 and the FSM returns to RST_HOLD. No partial-line recovery.

## Timing
- Reset values: h_cnt=0, v_cnt=0, FSM=RST_HOLD. Outputs at reset: `lcd_hs`=0, `lcd_vs`=0, `lcd_de`=0, `data_req`=0, `pixel_xpos`=0, `pixel_ypos`=0, `lcd_rgb`=0, `frame_start`=1 (counters at 0), `lcd_rst`=0, `lcd_bl`=0.
- Sync, DE and position outputs are combinational decodes of registered counters only, with no input-to-output paths except `lcd_rgb`.
- `pixel_data` sampled with `lcd_de` high corresponds to the request made PIX_LAT cycles earlier.
- PIX_LAT=0: `data_req` equals `lcd_de`.
- First active line is v_cnt=12. First `data_req` is at h_cnt=42, i.e. cycle 12·525+42=6342 after release. `lcd_de` rises at cycle 6343.
- Frame period is 150150 cycles. `frame_start` period is identical.

## Structure
- Shared package `lcd_timing_pkg`: panel timing constants per supported panel (480x272 default, 800x480), the RGB565 width constant, and the sequencer state enum.
- Sub-module `lcd_panel_seq` holds the RST_HOLD/WAIT_FRAME/RUN FSM and the RST_CYC counter. Inputs: `lcd_pclk`, `rst_n`, `frame_start`. Outputs: `lcd_rst`, `lcd_bl`.

## Test plan
- Reset release, defaults: `lcd_hs` low for 41 cycles per line. `lcd_vs` low for 10·525=5250 cycles. Line period 525 cycles, frame period 150150 cycles.
- Window check, PIX_LAT=1: `data_req` high h_cnt 42..521 and `lcd_de` high h_cnt 43..522, on v_cnt 12..283 only. `pixel_xpos` runs 1..480 and `pixel_ypos` runs 1..272. Exactly 130560 DE cycles per frame.
- Latency alignment: a model source registers `pixel_data` = {ypos[4:0], xpos[10:0]}. At the first DE cycle `lcd_rgb`=16'h0801. At the last DE cycle of the frame `lcd_rgb`=16'h81E0. Outside DE, `lcd_rgb`=0.
- PIX_LAT=0 and PIX_LAT=3: `data_req` leads `lcd_de` by exactly 0 and 3 cycles respectively, and xpos=1 aligns accordingly.
- Panel sequence: `lcd_rst` is 0 for exactly 1000 cycles after release. `lcd_bl` rises the cycle after the first `frame_start` following that, at cycle 150151.
- Mid-frame reset at v_cnt=100, h_cnt=200: all outputs return to reset values asynchronously. After release the frame restarts from h_cnt=0, and `lcd_rst` is low again for 1000 cycles.
